// File: rtl/ddr_cmd_initiator_if.sv
// Host-side request/response bundle for the DDR command initiator.
// The master drives requests; the slave (the initiator) returns ready and read data.
interface ddr_cmd_initiator_if #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8
);
    logic                         req_valid;
    logic                         req_ready;
    logic                         req_write;
    logic [BGWIDTH-1:0]           req_bg;
    logic [BAWIDTH-1:0]           req_ba;
    logic [ADDRWIDTH-1:0]         req_row;
    logic [COLWIDTH-1:0]          req_col;
    logic [BL*DEVICE_WIDTH-1:0]   req_wdata;
    logic                         rsp_valid;
    logic [BL*DEVICE_WIDTH-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_write, req_bg, req_ba, req_row, req_col, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_bg, req_ba, req_row, req_col, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ddr_cmd_initiator.sv
// Closed-page DDR command initiator: one ACT / RD-or-WR / PRE sequence per request,
// with a write burst driver, read burst capture and a whole-datapath halt freeze.
module ddr_cmd_initiator #(
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int TRCD         = 4,
    parameter int TCL          = 4,
    parameter int TCWL         = 2,
    parameter int TWR          = 2,
    parameter int TRP          = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    halt,
    ddr_cmd_initiator_if.slave      host,
    output logic [2:0]              cmd,
    output logic [BGWIDTH-1:0]      bg,
    output logic [BAWIDTH-1:0]      ba,
    output logic [ADDRWIDTH-1:0]    row,
    output logic [COLWIDTH-1:0]     column,
    output logic [DEVICE_WIDTH-1:0] dq_o,
    output logic                    dq_oe,
    input  logic [DEVICE_WIDTH-1:0] dq_i,
    output logic                    dqs_t,
    output logic                    dqs_c
);
    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_T  = max_of(max_of(max_of(TRCD, TCL), max_of(TCWL, TWR)), TRP);
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int BEAT_W = (BL > 1) ? $clog2(BL) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BL - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT, S_TRCD_WAIT, S_CAS, S_DATA_WAIT,
        S_BURST, S_TWR_WAIT, S_PRE, S_TRP_WAIT
    } state_t;

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [BEAT_W-1:0]        beat_reg;
    logic                     lat_write_reg;
    logic [COLWIDTH-1:0]      lat_col_reg;
    logic [BL*DEVICE_WIDTH-1:0] lat_wdata_reg;
    logic [BGWIDTH-1:0]       bg_reg;
    logic [BAWIDTH-1:0]       ba_reg;
    logic [ADDRWIDTH-1:0]     row_reg;
    logic [COLWIDTH-1:0]      col_reg;
    logic [DEVICE_WIDTH-1:0]  rbeat_reg [BL];
    logic [DEVICE_WIDTH-1:0]  wbeat     [BL];
    logic [BL*DEVICE_WIDTH-1:0] rdata_packed;
    logic                     burst_wr;

    genvar gi;
    generate
        for (gi = 0; gi < BL; gi++) begin : g_beats
            assign wbeat[gi] = lat_wdata_reg[gi*DEVICE_WIDTH +: DEVICE_WIDTH];
            assign rdata_packed[gi*DEVICE_WIDTH +: DEVICE_WIDTH] = rbeat_reg[gi];
        end
    endgenerate

    assign host.rsp_rdata = rdata_packed;
    assign bg     = bg_reg;
    assign ba     = ba_reg;
    assign row    = row_reg;
    assign column = col_reg;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Each wait state is loaded with (cycles in state - 1) on entry; a timing
    // value that leaves no extra wait cycles skips its wait state entirely.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (!halt) begin
            case (state_reg)
                S_IDLE: if (host.req_valid) state_next = S_ACT;
                S_ACT: begin
                    if (TRCD > 1) begin
                        state_next = S_TRCD_WAIT;
                        cnt_next   = CNT_W'(TRCD - 2);
                    end else begin
                        state_next = S_CAS;
                    end
                end
                S_TRCD_WAIT: begin
                    if (cnt_reg == '0) state_next = S_CAS;
                    else               cnt_next   = cnt_reg - 1'b1;
                end
                S_CAS: begin
                    if (lat_write_reg ? (TCWL > 1) : (TCL > 1)) begin
                        state_next = S_DATA_WAIT;
                        cnt_next   = lat_write_reg ? CNT_W'(TCWL - 2) : CNT_W'(TCL - 2);
                    end else begin
                        state_next = S_BURST;
                    end
                end
                S_DATA_WAIT: begin
                    if (cnt_reg == '0) state_next = S_BURST;
                    else               cnt_next   = cnt_reg - 1'b1;
                end
                S_BURST: begin
                    if (beat_reg == BEAT_LAST) begin
                        if (lat_write_reg && (TWR > 0)) begin
                            state_next = S_TWR_WAIT;
                            cnt_next   = CNT_W'(TWR - 1);
                        end else begin
                            state_next = S_PRE;
                        end
                    end
                end
                S_TWR_WAIT: begin
                    if (cnt_reg == '0) state_next = S_PRE;
                    else               cnt_next   = cnt_reg - 1'b1;
                end
                S_PRE: begin
                    if (TRP > 1) begin
                        state_next = S_TRP_WAIT;
                        cnt_next   = CNT_W'(TRP - 2);
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_TRP_WAIT: begin
                    if (cnt_reg == '0) state_next = S_IDLE;
                    else               cnt_next   = cnt_reg - 1'b1;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg       <= '0;
            beat_reg      <= '0;
            lat_write_reg <= 1'b0;
            lat_col_reg   <= '0;
            lat_wdata_reg <= '0;
            bg_reg        <= '0;
            ba_reg        <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            for (int i = 0; i < BL; i++) rbeat_reg[i] <= '0;
        end else if (!halt) begin
            cnt_reg <= cnt_next;
            if (state_reg == S_IDLE && host.req_valid) begin
                lat_write_reg <= host.req_write;
                lat_col_reg   <= host.req_col;
                lat_wdata_reg <= host.req_wdata;
                bg_reg        <= host.req_bg;
                ba_reg        <= host.req_ba;
                row_reg       <= host.req_row;
            end
            if (state_next == S_CAS && state_reg != S_CAS) col_reg <= lat_col_reg;
            if (state_reg == S_BURST && beat_reg != BEAT_LAST) beat_reg <= beat_reg + 1'b1;
            else                                               beat_reg <= '0;
            if (state_reg == S_BURST && !lat_write_reg) rbeat_reg[beat_reg] <= dq_i;
        end
    end

    assign burst_wr = (state_reg == S_BURST) && lat_write_reg && !halt;

    always_comb begin
        cmd            = CMD_NOP;
        host.req_ready = (state_reg == S_IDLE) && !halt;
        host.rsp_valid = (state_reg == S_PRE) && !lat_write_reg && !halt;
        dq_oe          = burst_wr;
        dq_o           = burst_wr ? wbeat[beat_reg] : '0;
        dqs_t          = burst_wr && !beat_reg[0];
        dqs_c          = burst_wr && beat_reg[0];
        if (!halt) begin
            case (state_reg)
                S_ACT:   cmd = CMD_ACT;
                S_CAS:   cmd = lat_write_reg ? CMD_WR : CMD_RD;
                S_PRE:   cmd = CMD_PRE;
                default: cmd = CMD_NOP;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr_cmd_initiator.sv
// Directed and randomized transactions checked against a cycle schedule derived
// from the timing rules; halted cycles simply do not advance that schedule.
module tb_ddr_cmd_initiator;
    localparam int DW = 4, BLEN = 8;
    localparam int TRCD = 4, TCL = 4, TCWL = 2, TWR = 2, TRP = 4;

    logic        clk = 1'b0;
    logic        reset, halt;
    logic [2:0]  cmd;
    logic [1:0]  bg, ba;
    logic [16:0] row;
    logic [9:0]  column;
    logic [3:0]  dq_o, dq_i;
    logic        dq_oe, dqs_t, dqs_c;

    ddr_cmd_initiator_if host ();

    ddr_cmd_initiator dut (
        .clk(clk), .reset(reset), .halt(halt), .host(host),
        .cmd(cmd), .bg(bg), .ba(ba), .row(row), .column(column),
        .dq_o(dq_o), .dq_oe(dq_oe), .dq_i(dq_i), .dqs_t(dqs_t), .dqs_c(dqs_c)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    string cur   = "init";

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s: got 0x%0h, expected 0x%0h", cur, tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_cmd", cmd, 0);
        chk("rst_oe", dq_oe, 0);
        chk("rst_dqs_t", dqs_t, 0);
        chk("rst_dqs_c", dqs_c, 0);
        chk("rst_rsp_valid", host.rsp_valid, 0);
        chk("rst_rdata", host.rsp_rdata, 0);
        chk("rst_addr", {bg, ba, row, column}, 0);
        chk("rst_dq_o", dq_o, 0);
        chk("rst_ready", host.req_ready, 1);
    endtask

    task automatic randomize_req_fields();
        host.req_write = 1'($urandom);
        host.req_bg    = 2'($urandom);
        host.req_ba    = 2'($urandom);
        host.req_row   = 17'($urandom);
        host.req_col   = 10'($urandom);
        host.req_wdata = $urandom;
    endtask

    // Entered inside cycle 0 (before its rising edge). Returns at the negedge of
    // the cycle where req_ready is expected again (or after the reset check).
    task automatic do_txn(input string name, input bit wr, input logic [1:0] bgv,
                          input logic [1:0] bav, input logic [16:0] rowv,
                          input logic [9:0] colv, input logic [31:0] wd,
                          input logic [31:0] rd, input int hs, input int hl,
                          input int rst_at, input bit keep_valid, input bit b2b);
        int cas, bs, last, pre, rdy, a, k;
        bit h, done, in_b;
        logic [2:0] e_cmd;
        cur  = name;
        cas  = 1 + TRCD;
        bs   = cas + (wr ? TCWL : TCL);
        last = bs + BLEN - 1;
        pre  = wr ? last + TWR + 1 : last + 1;
        rdy  = pre + TRP;
        host.req_valid = 1'b1;
        host.req_write = wr;
        host.req_bg    = bgv;
        host.req_ba    = bav;
        host.req_row   = rowv;
        host.req_col   = colv;
        host.req_wdata = wd;
        halt = 1'b0;
        if (!b2b) begin
            @(negedge clk);
            chk("ready_c0", host.req_ready, 1);
        end
        a = 0;
        done = 1'b0;
        for (int c = 1; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            if (rst_at > 0 && c == rst_at + 1) begin
                reset = 1'b0;
                host.req_valid = 1'b0;
                @(negedge clk);
                chk_reset_state();
                for (int j = 0; j < 6; j++) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                    chk("no_pre_after_rst", cmd, 0);
                    chk("idle_after_rst", host.req_ready, 1);
                end
                done = 1'b1;
            end else begin
                h = (c >= hs) && (c < hs + hl);
                halt = h;
                if (!h) a++;
                host.req_valid = keep_valid;
                randomize_req_fields();
                dq_i = 4'($urandom);
                if (!h && !wr && a >= bs && a <= last) dq_i = rd[(a - bs)*DW +: DW];
                if (rst_at > 0 && c == rst_at) reset = 1'b1;
                @(negedge clk);
                e_cmd = 3'd0;
                if (!h) begin
                    if (a == 1)        e_cmd = 3'd1;
                    else if (a == cas) e_cmd = wr ? 3'd3 : 3'd2;
                    else if (a == pre) e_cmd = 3'd4;
                end
                chk("cmd", cmd, e_cmd);
                if (!h && a == 1)   chk("act_addr", {bg, ba, row}, {bgv, bav, rowv});
                if (!h && a == cas) chk("cas_addr", {bg, ba, column}, {bgv, bav, colv});
                in_b = !h && wr && a >= bs && a <= last;
                k = a - bs;
                chk("dq_oe", dq_oe, in_b);
                if (in_b) chk("dq_o", dq_o, wd[k*DW +: DW]);
                chk("dqs_t", dqs_t, in_b && (k % 2 == 0));
                chk("dqs_c", dqs_c, in_b && (k % 2 == 1));
                chk("rsp_valid", host.rsp_valid, !h && !wr && a == pre);
                if (!h && !wr && a == pre) chk("rsp_rdata", host.rsp_rdata, rd);
                chk("req_ready", host.req_ready, !h && a == rdy);
                if (!h && a == rdy) done = 1'b1;
            end
        end
        if (!done) chk("timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_keep, keep;
        reset = 1'b1;
        halt = 1'b0;
        dq_i = '0;
        host.req_valid = 1'b0;
        randomize_req_fields();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        cur = "reset";
        chk_reset_state();

        @(posedge clk); #1;
        do_txn("write_basic", 1, 2'd1, 2'd2, 17'h1ABC, 10'h040, 32'h76543210, 32'h0,
               100, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_txn("read_basic", 0, 2'd3, 2'd1, 17'h0F00F, 10'h3FF, 32'h0, 32'hFEDCBA98,
               100, 0, 0, 0, 0);
        @(posedge clk); #1;
        do_txn("read_halt", 0, 2'd0, 2'd3, 17'h12345, 10'h155, 32'h0, 32'hFEDCBA98,
               10, 3, 0, 0, 0);
        @(posedge clk); #1;
        do_txn("write_reset", 1, 2'd2, 2'd0, 17'h1FFFF, 10'h2AA, 32'hA5C3E1F0, 32'h0,
               100, 0, 10, 0, 0);
        @(posedge clk); #1;
        do_txn("b2b_first", 1, 2'd1, 2'd1, 17'h00001, 10'h001, 32'h13579BDF, 32'h0,
               100, 0, 0, 1, 0);
        do_txn("b2b_second", 0, 2'd2, 2'd2, 17'h00002, 10'h002, 32'h0, 32'h2468ACE0,
               100, 0, 0, 0, 1);

        prev_keep = 1'b0;
        for (int i = 0; i < 10; i++) begin
            keep = (i < 9) ? 1'($urandom) : 1'b0;
            if (!prev_keep) begin
                @(posedge clk); #1;
            end
            do_txn($sformatf("rand%0d", i), 1'($urandom), 2'($urandom), 2'($urandom),
                   17'($urandom), 10'($urandom), $urandom, $urandom,
                   int'($urandom_range(1, 24)), int'($urandom_range(0, 3)),
                   0, keep, prev_keep);
            prev_keep = keep;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ddr_cmd_initiator.md
DDR_CMD_INITIATOR -- requirements
Module: ddr_cmd_initiator

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- BGWIDTH, 2, bank-group address width
- BAWIDTH, 2, bank address width
- ADDRWIDTH, 17, row address width
- COLWIDTH, 10, column address width
- DEVICE_WIDTH, 4, DQ width
- BL, 8, burst length in beats
- TRCD, 4, cycles from ACT to RD/WR
- TCL, 4, cycles from RD to first read beat
- TCWL, 2, cycles from WR to first write beat
- TWR, 2, cycles from last write beat to PRE
- TRP, 4, cycles from PRE to req_ready
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- halt  in  1  emulation freeze
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_bg  in  BGWIDTH  bank group
- req_ba  in  BAWIDTH  bank
- req_row  in  ADDRWIDTH  row
- req_col  in  COLWIDTH  column
- req_wdata  in  BL*DEVICE_WIDTH  write burst, beat 0 in LSBs
- rsp_valid  out  1  one-cycle read-data strobe
- rsp_rdata  out  BL*DEVICE_WIDTH  read burst, beat 0 in LSBs
- cmd  out  3  NOP=0, ACT=1, RD=2, WR=3, PRE=4
- bg, ba, row, column  out  widths as req_*  command address
- dq_o  out  DEVICE_WIDTH  write beat
- dq_oe  out  1  dq_o/dqs drive enable
- dq_i  in  DEVICE_WIDTH  read beat from device
- dqs_t, dqs_c  out  1 each  write strobe pair

Function
REQ-003 SHALL implement a closed-page FSM with states IDLE, ACT, TRCD_WAIT, CAS, DATA_WAIT, BURST, TWR_WAIT, PRE, TRP_WAIT.
REQ-004 SHALL assert req_ready only in IDLE with halt low; a handshake latches all req_* fields, and ACT follows in the next cycle.
REQ-005 SHALL output cmd=ACT for exactly one cycle with latched bg/ba/row.
REQ-006 SHALL output cmd=RD or WR for exactly one cycle, exactly TRCD cycles after ACT, with latched bg/ba/column.
REQ-007 SHALL output cmd=NOP in every cycle without a command; bg/ba/row/column hold their last values.
REQ-008 Write: SHALL drive BL consecutive beats starting TCWL cycles after WR, beat k = req_wdata[k*DEVICE_WIDTH +: DEVICE_WIDTH], with dq_oe=1 only during these beats.
REQ-009 Write: during beat k, SHALL drive dqs_t = ~k[0] and dqs_c = k[0]; outside a burst, dqs_t=dqs_c=0.
REQ-010 Write: SHALL issue PRE TWR+1 cycles after the last beat.
REQ-011 Read: SHALL sample dq_i into beat k on BL consecutive cycles starting TCL cycles after RD.
REQ-012 Read: SHALL pulse rsp_valid for one cycle, with the full rsp_rdata, in the cycle after the last sample, and issue PRE in that same cycle.
REQ-013 SHALL reassert req_ready exactly TRP cycles after PRE.
REQ-014 While halt=1, SHALL freeze state, counters and latched data, force cmd=NOP, dq_oe=0 and rsp_valid=0, and skip dq_i sampling; operation SHALL resume from the same point when halt clears.
REQ-015 Wait counters SHALL be sized from the largest timing parameter; any timing parameter equal to 1 SHALL give zero extra wait cycles.
REQ-016 Requests presented outside IDLE SHALL be ignored (no latch, req_ready=0).

Reset
REQ-017 Reset SHALL force, in the next cycle: state IDLE, cmd=NOP, dq_oe=0, dqs_t=dqs_c=0, rsp_valid=0, rsp_rdata=0, bg/ba/row/column=0, dq_o=0, req_ready=1.
REQ-018 Reset mid-operation SHALL abandon the transaction without issuing PRE or rsp_valid.

Verification (defaults; handshake at cycle 0)
REQ-019 Write, bg=1 ba=2 row=0x1ABC col=0x040 wdata=0x76543210 -> ACT c1, WR c5, dq_o 0..7 c7-c14 with dqs_t 1,0,1,..., PRE c17, req_ready c21.
REQ-020 Read, dq_i=beat index+8 -> ACT c1, RD c5, samples c9-c16, rsp_valid c17 with rdata 0xFEDCBA98, PRE c17, req_ready c21.
REQ-021 Read with halt high c10-c12 -> samples and subsequent events shift by 3 cycles; rdata unchanged; no rsp_valid during halt.
REQ-022 Reset at c10 of a write -> c11: IDLE, dq_oe=0, cmd=NOP, req_ready=1; no PRE.
REQ-023 req_valid held high across back-to-back transactions -> second ACT exactly 1 cycle after req_ready reasserts; no request accepted while busy.
